// File: rtl/rs_branch_q_if.sv
// Signal bundle between rs_branch_q and its environment (allocator, CDB snoop, branch unit).
// master: environment side driving allocations, broadcasts and out_ready.
// slave: the reservation station itself.
interface rs_branch_q_if #(
    parameter int DEPTH = 4,
    parameter int NCH   = 3,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // global controls
    logic                    rdy;
    logic                    flush;

    // allocate side
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         in_pc;
    logic [OP_W-1:0]         in_op;
    logic [XLEN-1:0]         in_imm;
    logic [TAG_W-1:0]        in_tagx;
    logic [TAG_W-1:0]        in_tagy;
    logic [XLEN-1:0]         in_datax;
    logic [XLEN-1:0]         in_datay;

    // result broadcast snoop
    logic [NCH-1:0]          cdb_valid;
    logic [NCH*TAG_W-1:0]    cdb_tag;
    logic [NCH*XLEN-1:0]     cdb_data;

    // issue side
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_pc;
    logic [XLEN-1:0]         out_imm;
    logic [OP_W-1:0]         out_op;
    logic [XLEN-1:0]         out_datax;
    logic [XLEN-1:0]         out_datay;

    logic [CNT_W-1:0]        count;

    modport master (
        output rdy, flush,
        output in_valid, in_pc, in_op, in_imm, in_tagx, in_tagy, in_datax, in_datay,
        input  in_ready,
        output cdb_valid, cdb_tag, cdb_data,
        input  out_valid, out_pc, out_imm, out_op, out_datax, out_datay,
        output out_ready,
        input  count
    );

    modport slave (
        input  rdy, flush,
        input  in_valid, in_pc, in_op, in_imm, in_tagx, in_tagy, in_datax, in_datay,
        output in_ready,
        input  cdb_valid, cdb_tag, cdb_data,
        output out_valid, out_pc, out_imm, out_op, out_datax, out_datay,
        input  out_ready,
        output count
    );
endinterface

// File: rtl/rs_branch_q.sv
// Branch reservation station: compacting age-ordered queue that snoops CDB channels and issues the oldest ready entry.
// Latency: allocate-to-issue and wakeup-to-issue are 1 cycle; no combinational CDB-to-out path.
// Backpressure: in_ready drops when full (no full-bypass); out_* hold while out_valid & !out_ready unless an older entry wakes.
module rs_branch_q #(
    parameter int DEPTH = 4,
    parameter int NCH   = 3,
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int OP_W  = 6
) (
    input logic          clk,
    input logic          rst_n,
    rs_branch_q_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tagx;
        logic [TAG_W-1:0] tagy;
        logic [XLEN-1:0]  datax;
        logic [XLEN-1:0]  datay;
    } entry_t;

    entry_t           slot_q [DEPTH];
    entry_t           slot_d [DEPTH];
    entry_t           work   [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_shift;

    logic [IDX_W-1:0] sel;
    logic             any_ready;
    entry_t           sel_entry;
    entry_t           new_entry;
    logic             in_ready;
    logic             out_valid;
    logic             do_alloc;
    logic             do_issue;
    logic [TAG_W-1:0] tx;
    logic [TAG_W-1:0] ty;

    // Oldest ready slot: scan high-to-low so the lowest matching index is left in sel.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < int'(count_q) && slot_q[i].tagx == '0 && slot_q[i].tagy == '0) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign sel_entry = slot_q[sel];

    // rst_n gates in_ready so the allocator sees no space while the queue is held in reset.
    assign in_ready  = rst_n & bus.rdy & (count_q < CNT_W'(DEPTH));
    assign out_valid = bus.rdy & any_ready;
    assign do_alloc  = bus.in_valid & in_ready & ~bus.flush;
    assign do_issue  = out_valid & bus.out_ready & ~bus.flush;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = sel_entry.pc;
    assign bus.out_imm   = sel_entry.imm;
    assign bus.out_op    = sel_entry.op;
    assign bus.out_datax = sel_entry.datax;
    assign bus.out_datay = sel_entry.datay;
    assign bus.count     = count_q;

    // Incoming instruction packed into slot format; wakeup is applied later with the stored slots.
    always_comb begin
        new_entry       = '0;
        new_entry.pc    = bus.in_pc;
        new_entry.op    = bus.in_op;
        new_entry.imm   = bus.in_imm;
        new_entry.tagx  = bus.in_tagx;
        new_entry.tagy  = bus.in_tagy;
        new_entry.datax = bus.in_datax;
        new_entry.datay = bus.in_datay;
    end

    // Next state: compact out the issued slot, append the new entry, then wake every valid slot.
    always_comb begin
        slot_d      = slot_q;
        count_d     = count_q;
        work        = slot_q;
        count_shift = count_q;
        tx          = '0;
        ty          = '0;
        if (bus.rdy) begin
            if (bus.flush) begin
                count_d = '0;
            end else begin
                if (do_issue) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (i >= int'(sel)) begin
                            work[i] = slot_q[i + 1];
                        end
                    end
                end
                count_shift = count_q - CNT_W'(do_issue);
                if (do_alloc) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(count_shift)) begin
                            work[i] = new_entry;
                        end
                    end
                end
                count_d = count_shift + CNT_W'(do_alloc);

                // Original tags are latched first; descending channel scan lets the lowest channel win.
                for (int i = 0; i < DEPTH; i++) begin
                    if (i < int'(count_d)) begin
                        tx = work[i].tagx;
                        ty = work[i].tagy;
                        for (int c = NCH - 1; c >= 0; c--) begin
                            if (bus.cdb_valid[c] && tx != '0 &&
                                bus.cdb_tag[c*TAG_W +: TAG_W] == tx) begin
                                work[i].tagx  = '0;
                                work[i].datax = bus.cdb_data[c*XLEN +: XLEN];
                            end
                            if (bus.cdb_valid[c] && ty != '0 &&
                                bus.cdb_tag[c*TAG_W +: TAG_W] == ty) begin
                                work[i].tagy  = '0;
                                work[i].datay = bus.cdb_data[c*XLEN +: XLEN];
                            end
                        end
                    end
                end
                slot_d = work;
            end
        end
    end

    // State registers; reset wipes every slot so out_* read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end
endmodule

// File: doc/rs_branch_q.md
# rs_branch_q

Multi-entry, parametrised branch reservation station. It sits between the dispatch allocator and the branch execution unit. It holds up to DEPTH in-flight branch instructions and snoops NCH result broadcast channels to resolve pending operands. Each cycle it offers the oldest entry whose operands are both resolved to the branch unit through a valid/ready handshake. A flush input discards all entries on redirect.

## Interface
- DEPTH, 4: number of entries, 2..16
- NCH, 3: number of result broadcast channels (ALU0, ALU1, LS by default)
- XLEN, 32: data/address width
- TAG_W, 4: register tag width; tag value 0 is UNLOCKED (operand resolved)
- OP_W, 6: branch sub-opcode width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  discard all entries
- in_valid  in  1  allocator presents an instruction
- in_ready  out  1  entry available
- in_pc  in  XLEN  instruction pc
- in_op  in  OP_W  branch op
- in_imm  in  XLEN  branch offset
- in_tagx, in_tagy  in  TAG_W  operand tags
- in_datax, in_datay  in  XLEN  operand data, meaningful when the tag is 0
- cdb_valid  in  NCH  per-channel broadcast valid
- cdb_tag  in  NCH*TAG_W  channel c at bits [c*TAG_W +: TAG_W]
- cdb_data  in  NCH*XLEN  channel c at bits [c*XLEN +: XLEN]
- out_valid  out  1  ready entry offered
- out_ready  in  1  branch unit accepts
- out_pc, out_imm  out  XLEN  selected entry fields
- out_op  out  OP_W
- out_datax, out_datay  out  XLEN  resolved operands
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- **Storage.** Compacting queue. Slot 0 holds the oldest entry, and slots 0..count-1 are valid. Each slot holds pc, op, imm, tagx, tagy, datax and datay.
- **Allocate.** Allocation occurs when in_valid & in_ready & rdy & !flush.
  - in_ready = rdy & (count < DEPTH). No full-bypass.
- **Issue.** Issue occurs when out_valid & out_ready & rdy & !flush.
  - out_valid = rdy & some valid slot has tagx == 0 && tagy == 0.
  - The selected slot is the lowest-indexed such slot, which is the oldest.
  - out_* fields are driven combinationally from the selected slot. When out_valid = 0 they are don't-care.
- **Issue and allocate in the same cycle.**
  - Slots above the issued slot k shift down by one.
  - The new entry is written at slot count-1 when an issue occurs that cycle, otherwise at slot count.
  - count changes by alloc − issue.
- **Wakeup (stored slots).** For each valid slot (after shifting) and each operand with tag ≠ 0:
  - If any channel c has cdb_valid[c] and cdb_tag[c] equal to that tag, set the tag to 0 and take the data from cdb_data[c].
  - If several channels match, the lowest c wins.
  - cdb_tag = 0 never matches.
- **Wakeup (incoming operands).** An incoming operand whose tag matches a same-cycle broadcast is stored resolved, with the same lowest-c rule.
- **Flush.** Sets count to 0 and discards all slots. It overrides allocate, issue and wakeup in that cycle.
- **rdy = 0.** No state change, and in_ready = out_valid = 0.
- **Reset.** Asserting rst_n low immediately clears count and every slot tag, pc, data, op and imm to 0. Outputs: in_ready = 0 while rst_n is low, out_valid = 0, count = 0, out_* = 0.

## Timing
- Allocate to issue: an instruction allocated at edge N with both tags 0 (or woken by the bypass) gives out_valid in cycle N+1. This is at minimum 1 cycle.
- Wakeup to issue: a broadcast at edge N makes the slot eligible in cycle N+1. There is no same-cycle path from CDB to out_*.
- Handshake: out_* remain stable while out_valid & !out_ready, unless an older entry wakes up and becomes the new selection. The branch unit must tolerate this re-selection.
- Full: at count = DEPTH, in_ready = 0 even if an issue occurs that cycle.
- Empty: out_valid = 0.
- Reset mid-operation: all entries are lost. Operation resumes on the first posedge after rst_n rises.

## Test plan
1. **Reset, single entry.** Release reset, then allocate pc=0x100, op=BEQ, tags 0, datax=datay=5. Required: out_valid=1 the next cycle with out_pc=0x100 and out_datax=5. After out_ready, count returns to 0.
2. **Wakeup via CDB.** Allocate tagx=3, tagy=0. Broadcast on channel 1: tag 3, data 0xDEAD. Required: out_valid=0 until the cycle after the broadcast, then out_datax=0xDEAD. Repeat with the broadcast in the allocate cycle: required out_valid=1 the next cycle.
3. **Age order.** Fill DEPTH=4 with A (tag 2 pending), then B, C, D all ready. Required: in_ready=0 and B issues first. Broadcast tag 2: required A (now oldest ready) issues next, then C, then D.
4. **Simultaneous alloc, issue, full.** With count=3, issue and allocate in the same cycle. Required: count stays 3 and the new entry lands at slot 2. At count=4 with out_ready=1, required in_ready=0.
5. **Flush and rdy.** With 3 entries plus an in_valid and a broadcast in the same cycle, assert flush. Required: count=0 the next cycle and the broadcast is ignored. Hold rdy=0 for 5 cycles with a matching broadcast present: required no state change and out_valid=0.
6. **Async reset.** Drop rst_n mid-cycle with count=2. Required: count=0 and out_valid=0 immediately, before the next edge.
